key_logic_debounce: RTL and testbench

- Parametrised successor to the two-key combinational gate used in the board bring-up projects.
- Synchronises and debounces NUM_KEYS raw push-button inputs, then combines the clean levels with a run-time selectable logic function (AND/OR/XOR/NAND).
- Drives one registered LED plus per-key clean levels and edge pulses.
- Sits directly between board key pins and LED/user logic.

---
 rtl/key_logic_debounce.sv | 82 ++++++++
 tb/tb_key_logic_debounce.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/key_logic_debounce.sv
// Key synchroniser and debouncer with a selectable logic function on the clean levels.
// Drives a registered LED plus per-key debounced levels and edge pulses.
module key_logic_debounce #(
  parameter  int NUM_KEYS   = 2,
  parameter  int DEB_CYCLES = 1000000,
  localparam int CNT_W      = $clog2(DEB_CYCLES + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key,
  input  logic [1:0]          mode,
  output logic [NUM_KEYS-1:0] key_stable,
  output logic [NUM_KEYS-1:0] key_rise,
  output logic [NUM_KEYS-1:0] key_fall,
  output logic                led
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [NUM_KEYS-1:0] sync1;
  logic [NUM_KEYS-1:0] key_sync;
  logic [CNT_W-1:0]    cnt [NUM_KEYS];
  logic                led_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= '0;
      key_sync <= '0;
    end else begin
      sync1    <= key;
      key_sync <= sync1;
    end
  end

  // A level is accepted only after DEB_CYCLES consecutive mismatches;
  // any agreement in between restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_stable <= '0;
      key_rise   <= '0;
      key_fall   <= '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        key_rise[i] <= 1'b0;
        key_fall[i] <= 1'b0;
        if (key_sync[i] == key_stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          cnt[i]        <= '0;
          key_stable[i] <= key_sync[i];
          key_rise[i]   <= key_sync[i];
          key_fall[i]   <= ~key_sync[i];
        end else begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end
      end
    end
  end

  always_comb begin
    led_next = 1'b0;
    unique case (mode)
      2'b00: led_next = &key_stable;
      2'b01: led_next = |key_stable;
      2'b10: led_next = ^key_stable;
      2'b11: led_next = ~&key_stable;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led <= 1'b0;
    end else begin
      led <= led_next;
    end
  end

endmodule

// File: tb/tb_key_logic_debounce.sv
// Randomised and directed bench for key_logic_debounce.
// A window-based reference model is compared after every clock edge.
module tb_key_logic_debounce;

  localparam int NK  = 2;
  localparam int DEB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NK-1:0] key;
  logic [1:0]    mode;
  logic [NK-1:0] key_stable;
  logic [NK-1:0] key_rise;
  logic [NK-1:0] key_fall;
  logic          led;

  int errors = 0;
  int checks = 0;

  key_logic_debounce #(
    .NUM_KEYS  (NK),
    .DEB_CYCLES(DEB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key       (key),
    .mode      (mode),
    .key_stable(key_stable),
    .key_rise  (key_rise),
    .key_fall  (key_fall),
    .led       (led)
  );

  always #5 clk = ~clk;

  // Reference: hist[j] holds the key sampled j+1 edges ago. A key flips
  // when the DEB samples the debouncer sees (two edges of sync delay)
  // all disagree with its current stable level.
  logic [NK-1:0] hist [0:DEB];
  logic [NK-1:0] m_stable = '0;
  logic [NK-1:0] m_rise   = '0;
  logic [NK-1:0] m_fall   = '0;
  logic          m_led    = 1'b0;

  function automatic logic lfun(logic [1:0] m, logic [NK-1:0] s);
    case (m)
      2'd0:    return s == {NK{1'b1}};
      2'd1:    return s != '0;
      2'd2:    return ($countones(s) % 2) == 1;
      default: return s != {NK{1'b1}};
    endcase
  endfunction

  always @(posedge clk) begin
    logic [NK-1:0] nxt;
    if (rst) begin
      m_stable = '0;
      m_rise   = '0;
      m_fall   = '0;
      m_led    = 1'b0;
      for (int j = 0; j <= DEB; j++) hist[j] = '0;
    end else begin
      m_led = lfun(mode, m_stable);
      nxt   = m_stable;
      for (int i = 0; i < NK; i++) begin
        bit all_diff;
        all_diff = 1'b1;
        for (int j = 1; j <= DEB; j++)
          if (hist[j][i] == m_stable[i]) all_diff = 1'b0;
        if (all_diff) nxt[i] = ~m_stable[i];
      end
      m_rise   = nxt & ~m_stable;
      m_fall   = ~nxt & m_stable;
      m_stable = nxt;
      for (int j = DEB; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = key;
    end
  end

  task automatic check(string nm, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0h expected %0h",
               nm, $time, act, exp);
    end
  endtask

  // Advance one edge, then compare the DUT against the model.
  task automatic tick();
    @(posedge clk);
    #1;
    check("model_stable", 8'(key_stable), 8'(m_stable));
    check("model_rise",   8'(key_rise),   8'(m_rise));
    check("model_fall",   8'(key_fall),   8'(m_fall));
    check("model_led",    8'(led),        8'(m_led));
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    logic [NK-1:0] k;
    logic          exp4 [4];
    int            rises;
    int            p;
    exp4[0] = 1'b0;
    exp4[1] = 1'b1;
    exp4[2] = 1'b1;
    exp4[3] = 1'b1;

    // 1: reset held with keys pressed in NAND mode
    rst  = 1'b1;
    key  = 2'b11;
    mode = 2'b11;
    for (int n = 0; n < 3; n++) begin
      tick();
      check("rst_stable", 8'(key_stable), 8'h0);
      check("rst_led",    8'(led),        8'h0);
      check("rst_pulses", 8'({key_rise, key_fall}), 8'h0);
    end
    rst = 1'b0;
    for (int n = 1; n <= 7; n++) begin
      tick();
      check("s1_stable", 8'(key_stable), (n >= 6) ? 8'h3 : 8'h0);
      check("s1_led",    8'(led),        (n >= 7) ? 8'h0 : 8'h1);
      check("s1_model",  8'(m_stable),   (n >= 6) ? 8'h3 : 8'h0);
    end

    // 2: clean press in AND mode
    key  = 2'b00;
    mode = 2'b00;
    idle(8);
    key = 2'b01;
    for (int n = 0; n <= 6; n++) begin
      tick();
      check("s2_stable", 8'(key_stable), (n >= 5) ? 8'h1 : 8'h0);
      check("s2_rise",   8'(key_rise),   (n == 5) ? 8'h1 : 8'h0);
      check("s2_led",    8'(led),        8'h0);
    end
    key = 2'b11;
    for (int n = 0; n <= 6; n++) begin
      tick();
      check("s2_led_and", 8'(led), (n >= 6) ? 8'h1 : 8'h0);
    end

    // 3: bounce on key[0], then a firm press
    key = 2'b00;
    idle(8);
    for (int n = 0; n < 8; n++) begin
      key[0] = ((n / 2) % 2) == 0;
      tick();
      check("s3_bounce", 8'(key_stable), 8'h0);
    end
    key = 2'b01;
    for (int n = 0; n <= 5; n++) begin
      tick();
      check("s3_accept", 8'(key_stable), (n >= 5) ? 8'h1 : 8'h0);
    end

    // 4: mode sweep with key_stable = 10
    key = 2'b10;
    idle(8);
    check("s4_stable", 8'(key_stable), 8'h2);
    for (int m = 0; m < 4; m++) begin
      mode = 2'(m);
      tick();
      check("s4_led", 8'(led), 8'(exp4[m]));
    end

    // 5: simultaneous release in OR mode
    mode = 2'b01;
    key  = 2'b11;
    idle(8);
    key = 2'b00;
    for (int n = 0; n <= 6; n++) begin
      tick();
      check("s5_fall", 8'(key_fall), (n == 5) ? 8'h3 : 8'h0);
      check("s5_led",  8'(led),      (n >= 6) ? 8'h0 : 8'h1);
    end

    // 6: reset in the middle of a count
    idle(8);
    key = 2'b10;
    idle(3);
    rst = 1'b1;
    tick();
    check("s6_rst", 8'(key_stable), 8'h0);
    rst   = 1'b0;
    rises = 0;
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (key_rise != '0) rises++;
      check("s6_stable", 8'(key_stable), (n >= 6) ? 8'h2 : 8'h0);
      check("s6_rise",   8'(key_rise),   (n == 6) ? 8'h2 : 8'h0);
    end
    check("s6_rise_cnt", 8'(rises), 8'h1);

    // Random: bursts with varying bounce rates, mode changes, rare resets
    p = 4;
    for (int c = 0; c < 3000; c++) begin
      if (c % 300 == 0) p = int'($urandom_range(9, 1));
      k = key;
      for (int b = 0; b < NK; b++)
        if ($urandom_range(p) == 0) k[b] = ~k[b];
      key = k;
      if ($urandom_range(15) == 0) mode = 2'($urandom_range(3));
      rst = ($urandom_range(199) == 0);
      tick();
    end
    rst = 1'b0;
    idle(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
